// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU.
// The granted request's ALU result is captured into a one-entry response register tagged with the requester ID.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_op1,
    input  logic [31:0]      req0_op2,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_op1,
    input  logic [31:0]      req1_op2,
    input  logic [3:0]       req1_ctrl,
    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Ready may depend on the other port's valid; valid must never depend on ready.
    logic last_grant;
    logic sel_valid;
    logic sel_id;
    logic can_accept;
    logic accept;

    always_comb begin
        sel_valid = req0_valid || req1_valid;
        sel_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_id = ~last_grant;
        end else if (req1_valid) begin
            sel_id = 1'b1;
        end
    end

    // The response register is free if empty or being drained this cycle.
    assign can_accept = (!rsp_valid || rsp_ready) && !rst;
    assign req0_ready = can_accept && sel_valid && !sel_id;
    assign req1_ready = can_accept && sel_valid && sel_id;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        alu_op1  = 32'd0;
        alu_op2  = 32'd0;
        alu_ctrl = 4'b1111;
        if (sel_valid) begin
            if (sel_id) begin
                alu_op1  = req1_op1;
                alu_op2  = req1_op2;
                alu_ctrl = req1_ctrl;
            end else begin
                alu_op1  = req0_op1;
                alu_op2  = req0_op2;
                alu_ctrl = req0_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 32'd0;
            last_grant <= 1'b1;
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= sel_id;
            rsp_data   <= alu_out;
            last_grant <= sel_id;
            if (!sel_id && gnt_cnt0 != '1) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (sel_id && gnt_cnt1 != '1) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU, driver tasks, and a scoreboard
// whose monitor pops expected {id, data} whenever a response transfers.
module tb_alu_arbiter;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic [31:0]      alu_op1, alu_op2, alu_out;
    logic [3:0]       alu_ctrl;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [31:0]      rsp_data;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    logic [31:0] e0, e1;
    logic [32:0] exp_q[$];
    int total;
    int bad;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // external ALU model
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_out = alu_op1 + alu_op2;
            4'b0001: alu_out = alu_op1 << alu_op2[4:0];
            4'b0010: alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            4'b0011: alu_out = {31'd0, alu_op1 < alu_op2};
            4'b0100: alu_out = alu_op1 ^ alu_op2;
            4'b0101: alu_out = alu_op1 >> alu_op2[4:0];
            4'b0110: alu_out = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            4'b0111: alu_out = alu_op1 | alu_op2;
            4'b1000: alu_out = alu_op1 & alu_op2;
            4'b1001: alu_out = alu_op1 - alu_op2;
            default: alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
        end
    endtask

    // driver tasks
    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] e);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c; e0 = e;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] e);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c; e1 = e;
    endtask

    // One cycle: optionally check readys at negedge, record accepted requests, end at posedge+1.
    task automatic tick(input logic r0, input logic r1, input bit do_chk, input string name);
        @(negedge clk);
        if (do_chk) begin
            chk({name, "_ready0"}, {31'd0, req0_ready}, {31'd0, r0});
            chk({name, "_ready1"}, {31'd0, req1_ready}, {31'd0, r1});
        end
        if (req0_valid && req0_ready) exp_q.push_back({1'b0, e0});
        if (req1_valid && req1_ready) exp_q.push_back({1'b1, e1});
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: act=%0d/%h req=none", rsp_id, rsp_data);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
                chk("rsp_data", rsp_data, e[31:0]);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b1, 32'd0, 32'd0, 4'd0, 32'd0);
        set1(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);

        // reset state, readys low while rst held
        tick(1'b0, 1'b0, 1'b1, "in_reset");
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_cnt0", {28'd0, gnt_cnt0}, 32'd0);
        chk("rst_cnt1", {28'd0, gnt_cnt1}, 32'd0);
        set0(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b1, "idle");

        // req0 add 5+7
        set0(1'b1, 32'd5, 32'd7, 4'b0000, 32'd12);
        tick(1'b1, 1'b0, 1'b1, "add");
        set0(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("add_rsp_data", rsp_data, 32'd12);
        chk("add_cnt0", {28'd0, gnt_cnt0}, 32'd1);

        // unknown control code
        set0(1'b1, 32'd3, 32'd4, 4'b1111, 32'd0);
        tick(1'b1, 1'b0, 1'b1, "unk");
        set0(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        chk("unk_rsp_data", rsp_data, 32'd0);
        chk("unk_cnt0", {28'd0, gnt_cnt0}, 32'd2);
        tick(1'b0, 1'b0, 1'b1, "unk_drain");
        chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // backpressure: req1 slt -1<1 held while consumer stalls
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1);
        rsp_ready = 1'b0;
        tick(1'b0, 1'b1, 1'b1, "bp_first");
        set1(1'b1, 32'h0000_000F, 32'h0000_00F0, 4'b0111, 32'h0000_00FF);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1, "bp_hold");
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'd1);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
        end
        rsp_ready = 1'b1;
        tick(1'b0, 1'b1, 1'b1, "bp_release");
        set1(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        chk("bp_new_data", rsp_data, 32'h0000_00FF);
        chk("bp_new_valid", {31'd0, rsp_valid}, 32'd1);

        // contention: last grant was port 1, so 0,1,0,1
        set0(1'b1, 32'd10, 32'd3, 4'b1001, 32'd7);
        set1(1'b1, 32'h8000_0000, 32'd4, 4'b0110, 32'hF800_0000);
        tick(1'b1, 1'b0, 1'b1, "cont0");
        tick(1'b0, 1'b1, 1'b1, "cont1");
        tick(1'b1, 1'b0, 1'b1, "cont2");
        chk("cont_data_mid", rsp_data, 32'd7);
        tick(1'b0, 1'b1, 1'b1, "cont3");
        chk("cont_data_end", rsp_data, 32'hF800_0000);
        set0(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        set1(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, "cont_drain");

        // reset mid-operation with a held response and a pending request
        rsp_ready = 1'b0;
        set1(1'b1, 32'd2, 32'd2, 4'b0000, 32'd4);
        tick(1'b0, 1'b1, 1'b1, "mr_fill");
        set1(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        set0(1'b1, 32'd1, 32'd1, 4'b0000, 32'd2);
        tick(1'b0, 1'b0, 1'b1, "mr_pend");
        chk("mr_valid_before", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_cnt0", {28'd0, gnt_cnt0}, 32'd0);
        chk("mr_cnt1", {28'd0, gnt_cnt1}, 32'd0);
        exp_q.delete();
        set1(1'b1, 32'd9, 32'd1, 4'b1001, 32'd8);
        tick(1'b0, 1'b0, 1'b1, "mr_in_reset");
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick(1'b1, 1'b0, 1'b1, "mr_first_cont");
        set0(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        tick(1'b0, 1'b1, 1'b1, "mr_second");
        set1(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        chk("mr_cnt1_after", {28'd0, gnt_cnt1}, 32'd1);

        // saturation on req1: 16 more accepts pass all-ones
        for (int i = 0; i < 16; i++) begin
            set1(1'b1, i, 32'd1, 4'b0001, i * 2);
            tick(1'b0, 1'b1, 1'b0, "sat");
            if (i == 13) chk("sat_cnt1_full", {28'd0, gnt_cnt1}, 32'd15);
        end
        chk("sat_cnt1_held", {28'd0, gnt_cnt1}, 32'd15);
        chk("sat_cnt0", {28'd0, gnt_cnt0}, 32'd1);
        set1(1'b0, 32'd0, 32'd0, 4'd0, 32'd0);

        tick(1'b0, 1'b0, 1'b1, "final_drain");
        tick(1'b0, 1'b0, 1'b0, "final_idle");
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single combinational ALU between two requesters, for example the execute stage (port 0) and a multi-cycle helper such as an address or branch-target unit (port 1). Each requester presents operands and a 4-bit ALU control code under a valid/ready handshake. The arbiter drives the ALU inputs for the granted requester and captures the ALU result into a one-entry response register. The result is returned with the requester ID under its own valid/ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of per-requester grant counters (saturating)

Ports (clock and reset first):
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 accepted this cycle
- req0_op1, req0_op2  input  32 each  requester 0 operands
- req0_ctrl  input  4  requester 0 ALU control code
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl  same as port 0, for requester 1
- alu_op1, alu_op2  output  32 each  ALU operands
- alu_ctrl  output  4  ALU control code
- alu_out  input  32  combinational ALU result
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer takes the response
- rsp_id  output  1  requester that owns the response
- rsp_data  output  32  registered ALU result
- gnt_cnt0, gnt_cnt1  output  CNT_W each  accepted-request counts, saturating at all-ones

## Operation
- ALU control encoding passes through unchanged:
  - 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor
  - 0101 srl, 0110 sra, 0111 or, 1000 and, 1001 sub
  - 1010–1111 are forwarded as-is; the ALU yields 0.
- can_accept = !rsp_valid || rsp_ready. This allows one transfer per cycle while the consumer drains.
- Grant selection (combinational) each cycle:
  - Only one requester valid: that requester is selected.
  - Both valid: select the requester that is not last_grant.
  - Neither valid: no selection.
- reqN_ready = can_accept && selected == N. At most one ready is high per cycle.
- reqN_ready may depend combinationally on the other requester's valid. Requesters must not make valid depend on ready.
- ALU drive:
  - Selected requester's op1/op2/ctrl go to alu_op1/alu_op2/alu_ctrl.
  - With no selection, drive 0/0/4'b1111. This applies even when can_accept is 0, so ALU inputs stay stable.
- Acceptance (reqN_valid && reqN_ready) on a clock edge:
  - rsp_data <= alu_out, rsp_id <= N, rsp_valid <= 1.
  - last_grant <= N.
  - gnt_cntN increments unless it is already all-ones.
- Drain with no acceptance (rsp_valid && rsp_ready, no acceptance in the same cycle): rsp_valid <= 0. rsp_data and rsp_id hold their values.
- Drain and acceptance in the same cycle: the new result replaces the old one and rsp_valid stays 1.
- No acceptance and no drain: all state holds. A requester holding valid keeps its operands stable until accepted.
- last_grant changes only on acceptance. A lone requester does not lose priority from idle cycles.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0
  - last_grant=1, so port 0 wins the first contention
  - gnt_cnt0=gnt_cnt1=0
  - While rst is asserted, req0_ready=req1_ready=0.
- Asserting rst mid-operation discards any held response immediately (asynchronously).
- Latency: a request accepted at edge k has rsp_valid=1 with its data after edge k.
- Throughput:
  - One request per cycle when rsp_ready is held at 1.
  - With both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Backpressure: while rsp_valid=1 and rsp_ready=0, both readys are 0 and the response holds stable.
- Counter saturation: at all-ones, an acceptance leaves the counter unchanged.

## Test plan
- Reset, then req0 only: op1=5, op2=7, ctrl=0000 → req0_ready=1; next cycle rsp_valid=1, rsp_id=0, rsp_data=12; gnt_cnt0=1.
- Contention:
  - Setup: both valid for 4 cycles, rsp_ready=1; req0 sub 10−3, req1 sra 0x80000000 by 4.
  - Required: grants 0,1,0,1; rsp_data alternates 7 and 0xF8000000.
  - Required: exactly one ready per cycle.
- Backpressure:
  - Setup: rsp_ready=0 after the first accept; req1 slt with −1<1.
  - Required: rsp_valid=1, rsp_data=1, rsp_id=1 held stable; both readys 0.
  - Required: when rsp_ready=1, the pending request is accepted that same cycle and its result replaces the old one.
- Unknown code: req0 ctrl=1111, op1=3, op2=4 → rsp_data=0 and gnt_cnt0 increments.
- Reset mid-operation:
  - Setup: assert rst while rsp_valid=1 and a request is pending.
  - Required: rsp_valid drops without waiting for a clock edge; counters return to 0.
  - Required: after release, the first contention grants port 0.
- Saturation: force 2^CNT_W accepts on req1 (CNT_W=4 build) → gnt_cnt1 stops at 15.
